// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for wide_add_sequencer: FSM encoding, default geometry,
// slice-count helpers and the single-bit full-adder function.
package wide_add_sequencer_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Flat constants so the state register stays a plain logic vector
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns {carry_out, sum} of one full adder
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/wide_add_sequencer_add_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full adders.
// With WIDE_ADD_SEQUENCER_OVERFLOW_EN it also exposes the carry into the MSB.
module add_slice
  import wide_add_sequencer_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
  ,
  output logic             msb_carry_in
`endif
);

  logic [SLICE:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign {carry_s[i+1], sum[i]} = full_add(a[i], b[i], carry_s[i]);
  end

  assign cout = carry_s[SLICE];

`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
  assign msb_carry_in = carry_s[SLICE-1];
`endif

endmodule

// File: rtl/wide_add_sequencer.sv
// Sequences one SLICE-bit adder over WIDTH/SLICE cycles behind valid/ready handshakes.
// Optional io_ovf signed-overflow output under WIDE_ADD_SEQUENCER_OVERFLOW_EN.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_cin,
  input  logic             io_sub,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_sum,
  output logic             io_cout,
`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
  output logic             io_ovf,
`endif
  output logic             io_busy
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

  if (((WIDTH % SLICE) != 0) || (NSLICE < 2)) begin : g_bad_cfg
    $error("wide_add_sequencer: WIDTH must be a multiple of SLICE with WIDTH/SLICE >= 2");
  end

  logic [1:0]                   state_r;
  logic [IDX_W-1:0]             idx_r;
  logic                         carry_r;
  logic [NSLICE-1:0][SLICE-1:0] a_r;
  logic [NSLICE-1:0][SLICE-1:0] b_r;
  logic [NSLICE-1:0][SLICE-1:0] result_r;

  logic [SLICE-1:0] sum_s;
  logic             cout_s;
`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
  logic             msb_cin_s;
  logic             ovf_r;
`endif

  add_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a            (a_r[idx_r]),
    .b            (b_r[idx_r]),
    .cin          (carry_r),
    .sum          (sum_s),
`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
    .msb_carry_in (msb_cin_s),
`endif
    .cout         (cout_s)
  );

  // FSM, operand capture and slice-by-slice accumulation of the result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      carry_r  <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (io_in_valid) begin
            a_r     <= io_a;
            // Subtract is A + ~B + 1, so the forced carry-in replaces io_cin
            b_r     <= io_sub ? ~io_b : io_b;
            carry_r <= io_sub ? 1'b1 : io_cin;
            idx_r   <= '0;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_r[idx_r] <= sum_s;
          carry_r         <= cout_s;
          if (idx_r == LAST_IDX) begin
            idx_r   <= '0;
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          if (io_out_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
  // Signed overflow sampled as the top slice is added, held until the next operation
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r <= 1'b0;
    end else if ((state_r == ST_RUN) && (idx_r == LAST_IDX)) begin
      ovf_r <= msb_cin_s ^ cout_s;
    end
  end

  assign io_ovf = ovf_r;
`endif

  assign io_in_ready  = (state_r == ST_IDLE);
  assign io_busy      = (state_r != ST_IDLE);
  assign io_out_valid = (state_r == ST_DONE);
  assign io_sum       = result_r;
  assign io_cout      = carry_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed self-checking bench for wide_add_sequencer at the default 32/8 geometry.
module tb_wide_add_sequencer;

  logic        clock;
  logic        reset_n;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_a;
  logic [31:0] io_b;
  logic        io_cin;
  logic        io_sub;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_sum;
  logic        io_cout;
  logic        io_busy;
`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
  logic        io_ovf;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  wide_add_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_a         (io_a),
    .io_b         (io_b),
    .io_cin       (io_cin),
    .io_sub       (io_sub),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_sum       (io_sum),
    .io_cout      (io_cout),
`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
    .io_ovf       (io_ovf),
`endif
    .io_busy      (io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts falling edges after the accepting edge until io_out_valid is seen
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!io_out_valid && lat < 20);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge, idle again
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub,
                        input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat;
    io_a = a; io_b = b; io_cin = cin; io_sub = sub;
    io_in_valid = 1'b1; io_out_ready = 1'b1;
    check_vec({tag, "_rdy"}, 64'(io_in_ready), 64'd1);
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    wait_done(lat);
    check_vec({tag, "_lat"}, 64'(lat), 64'd5);
    check_vec({tag, "_sum"}, 64'(io_sum), 64'(exp_sum));
    check_vec({tag, "_cout"}, 64'(io_cout), 64'(exp_cout));
`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
    check_vec({tag, "_ovf"}, 64'(io_ovf), 64'(exp_ovf));
`endif
    @(posedge clock);
    @(negedge clock);
    check_vec({tag, "_idle"}, 64'(io_in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int seen;
    reset_n = 1'b0;
    io_in_valid = 1'b0; io_out_ready = 1'b0;
    io_a = 32'd0; io_b = 32'd0; io_cin = 1'b0; io_sub = 1'b0;
    repeat (3) @(negedge clock);
    check_vec("rst_in_ready", 64'(io_in_ready), 64'd1);
    check_vec("rst_out_valid", 64'(io_out_valid), 64'd0);
    check_vec("rst_busy", 64'(io_busy), 64'd0);
    check_vec("rst_sum", 64'(io_sum), 64'd0);
    check_vec("rst_cout", 64'(io_cout), 64'd0);
`ifdef WIDE_ADD_SEQUENCER_OVERFLOW_EN
    check_vec("rst_ovf", 64'(io_ovf), 64'd0);
`endif
    reset_n = 1'b1;
    @(negedge clock);

    run_op("add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("ripple",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_5_7",   32'd5,         32'd7,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_7_5",   32'd7,         32'd5,         1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_op("mixed",     32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
    run_op("ovf_pos",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("wrap_neg1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Backpressure: hold the result while a new request waits outside
    io_a = 32'h10; io_b = 32'h20; io_cin = 1'b0; io_sub = 1'b0;
    io_in_valid = 1'b1; io_out_ready = 1'b0;
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    wait_done(lat);
    check_vec("bp_lat", 64'(lat), 64'd5);
    io_a = 32'd3; io_b = 32'd4; io_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_vec("bp_sum_hold", 64'(io_sum), 64'h30);
      check_vec("bp_in_ready", 64'(io_in_ready), 64'd0);
      check_vec("bp_out_valid", 64'(io_out_valid), 64'd1);
    end
    io_out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_vec("bp_release_idle", 64'(io_in_ready), 64'd1);
    check_vec("bp_release_valid", 64'(io_out_valid), 64'd0);
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    check_vec("bp_accept_busy", 64'(io_busy), 64'd1);
    wait_done(lat);
    check_vec("bp2_lat", 64'(lat), 64'd5);
    check_vec("bp2_sum", 64'(io_sum), 64'd7);
    @(posedge clock);
    @(negedge clock);

    // Reset while in RUN with idx=2
    io_a = 32'h0000_00FF; io_b = 32'h0000_0001; io_cin = 1'b0; io_sub = 1'b0;
    io_in_valid = 1'b1; io_out_ready = 1'b1;
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_vec("mid_rst_out_valid", 64'(io_out_valid), 64'd0);
    check_vec("mid_rst_busy", 64'(io_busy), 64'd0);
    check_vec("mid_rst_in_ready", 64'(io_in_ready), 64'd1);
    check_vec("mid_rst_sum", 64'(io_sum), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (io_out_valid) seen++;
    end
    check_vec("mid_rst_no_result", 64'(seen), 64'd0);
    check_vec("mid_rst_idle", 64'(io_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
